// File: rtl/mdu_unit.sv
// mdu_unit - multi-cycle multiply/divide unit holding the HI/LO registers.
//
// Handles MULT, MULTU, DIV, DIVU (multi-cycle, busy asserted for exactly
// MULT_LAT / DIV_LAT cycles) and MTHI/MTLO (single edge, never busy).
// MFHI/MFLO read HI/LO directly through the GRF write-back mux.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - asynchronous active-low reset, clears all state
//   start  - one-cycle request qualifying op/A/B (ignored while busy)
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   A      - rs operand
//   B      - rt operand
//   busy   - multi-cycle operation in progress
//   HI, LO - registered HI/LO values
module mdu_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [1:0]       mop_q,  mop_d;   // latched op[1:0]: bit1 = divide, bit0 = unsigned
  logic [31:0]      a_q,    a_d;
  logic [31:0]      b_q,    b_d;
  logic [31:0]      hi_q,   hi_d;
  logic [31:0]      lo_q,   lo_d;

  // Results from latched operands
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, quo_mag, rem_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes, then restore signs. 0x80000000 has
    // magnitude 0x80000000 as an unsigned value, so the -2^31 / -1 case
    // naturally yields quotient 0x80000000, remainder 0.
    a_mag   = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag   = b_q[31] ? (32'd0 - b_q) : b_q;
    quo_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
    rem_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
    quo_s   = (a_q[31] ^ b_q[31]) ? (32'd0 - quo_mag) : quo_mag;
    rem_s   = a_q[31] ? (32'd0 - rem_mag) : rem_mag;

    quo_u   = (b_q == '0) ? '0 : (a_q / b_q);
    rem_u   = (b_q == '0) ? '0 : (a_q % b_q);
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    mop_d  = mop_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;

    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        case (mop_q)
          2'b00: {hi_d, lo_d} = prod_s;
          2'b01: {hi_d, lo_d} = prod_u;
          2'b10: begin
            // divide by zero leaves HI/LO untouched
            if (b_q != '0) begin
              hi_d = rem_s;
              lo_d = quo_s;
            end
          end
          default: begin
            if (b_q != '0) begin
              hi_d = rem_u;
              lo_d = quo_u;
            end
          end
        endcase
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          busy_d = 1'b1;
          cnt_d  = CNT_W'(MULT_LAT);
          mop_d  = op[1:0];
          a_d    = A;
          b_d    = B;
        end
        OP_DIV, OP_DIVU: begin
          busy_d = 1'b1;
          cnt_d  = CNT_W'(DIV_LAT);
          mop_d  = op[1:0];
          a_d    = A;
          b_d    = B;
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      mop_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      mop_q  <= mop_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit - directed and randomized checks of mdu_unit against a
// behavioural HI/LO model using plain 64-bit arithmetic.
module tb_mdu_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one accepted operation on the model HI/LO.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (o)
      3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin pu = ua * ub; hi_m = pu[63:32]; lo_m = pu[31:0]; end
      3'd2: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
      3'd3: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  // Assumes we are at a negedge; request is accepted at the next posedge.
  // A/B are scrambled afterwards so the result must come from latched values.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; op = 3'(($urandom_range(0, 7)));
  endtask

  // Count sampled busy cycles (bounded), starting from 'already'.
  task automatic wait_busy(input string tag, input int lat, input int already);
    int c;
    c = already;
    while (busy === 1'b1 && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(c), 32'(lat));
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    model_apply(o, a, b);
    if (o <= 3'd3) wait_busy(tag, (o <= 3'd1) ? MULT_LAT : DIV_LAT, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, hi_m);
    chk({tag, "_lo"}, LO, lo_m);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    hi_m = '0; lo_m = '0;

    // Reset held with clock running, and a start that must be ignored
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd4; A = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    // MULT / MULTU
    do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_lo_const", LO, 32'hFFFF_FFFA);
    do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("multu_hi_const", HI, 32'h0000_0002);
    chk("multu_lo_const", LO, 32'hFFFF_FFFA);

    // DIV / DIVU
    do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", LO, 32'hFFFF_FFFD);
    chk("div_hi_const", HI, 32'hFFFF_FFFF);
    do_op("divu", 3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("divu_lo_const", LO, 32'h7FFF_FFFC);
    chk("divu_hi_const", HI, 32'h0000_0001);

    // Divide by zero leaves preloaded values
    do_op("mthi", 3'd4, 32'h11, 32'd0);
    do_op("mtlo", 3'd5, 32'h22, 32'd0);
    do_op("div0", 3'd2, 32'd1234, 32'd0);
    chk("div0_hi_const", HI, 32'h11);
    chk("div0_lo_const", LO, 32'h22);
    do_op("divu0", 3'd3, 32'hFFFF_0000, 32'd0);

    // Signed overflow case
    do_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divovf_lo_const", LO, 32'h8000_0000);
    chk("divovf_hi_const", HI, 32'h0000_0000);

    // MTHI during a MULT is ignored; operands are latched
    issue(3'd0, 32'h1234_5678, 32'h0000_0100);
    model_apply(3'd0, 32'h1234_5678, 32'h0000_0100);
    start = 1'b1; op = 3'd4; A = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    wait_busy("ignored", MULT_LAT, 1);
    chk("ignored_hi_const", HI, 32'h0000_0012);
    chk("ignored_lo_const", LO, 32'h3456_7800);
    chk("ignored_hi_model", HI, hi_m);

    // MTLO while idle
    do_op("mtlo5", 3'd5, 32'd5, 32'd0);
    chk("mtlo5_lo_const", LO, 32'd5);
    do_op("nop6", 3'd6, 32'hAAAA_AAAA, 32'd1);
    do_op("nop7", 3'd7, 32'h5555_5555, 32'd1);

    // Randomized, back-to-back issue
    for (int i = 0; i < 30; i++) begin
      ro = 3'(($urandom_range(0, 7)));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 50));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        default: rb = $urandom;
      endcase
      do_op("rand", ro, ra, rb);
    end

    // Reset asserted in the third busy cycle of a DIV
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (DIV_LAT + 5) @(negedge clk);
    chk("abort_late_busy", {31'd0, busy}, 32'd0);
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);

    // Unit still operational after abort
    do_op("after_abort", 3'd0, 32'd7, 32'd9);
    chk("after_abort_lo_const", LO, 32'd63);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit holding the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Sits directly downstream of the datapath's GRF read ports:
  - operand A is driven from RegRead1 (rs);
  - operand B is driven from RegRead2 (rt).
- HI/LO outputs feed a new input of the GRF write-back mux for MFHI/MFLO.
- busy tells the controller to stall any MDU-class instruction until the current operation finishes.

Parameters:
- MULT_LAT, 5, cycles from an accepted MULT/MULTU to HI/LO update (minimum 1).
- DIV_LAT, 10, cycles from an accepted DIV/DIVU to HI/LO update (minimum 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately, independent of clk.
- start  input  1  one-cycle request qualifying op, A and B.
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  multi-cycle operation in progress.
- HI  output  32  HI register, registered.
- LO  output  32  LO register, registered.

Behaviour:
- Reset (reset==0, asynchronous):
  - busy=0, HI=0, LO=0, cycle counter=0, latched operands=0.
  - Reset asserted mid-operation aborts it; no result is ever written.
- Idle (busy==0) and start==1 at a rising edge:
  - op 0–3: latch A, B and op; load counter with MULT_LAT (op 0/1) or DIV_LAT (op 2/3); busy=1 after that edge. HI/LO unchanged.
  - op 4: HI<=A at that edge. busy stays 0.
  - op 5: LO<=A at that edge. busy stays 0.
  - op 6/7: no effect.
- Busy:
  - Counter decrements once per edge.
  - At the edge where counter==1: write the result to HI/LO, clear busy, set counter=0.
  - busy is therefore high for exactly LAT cycles.
  - New HI/LO values are visible in the same cycle busy reads 0.
- start while busy==1: ignored entirely, including MTHI/MTLO. The controller guarantees this never happens.
- Controller stall rule: stall an MDU-class instruction (including MFHI/MFLO) when busy==1, or when start==1 for op 0–3 in the current cycle.
- Arithmetic, computed on the latched operands only; later changes to A/B have no effect:
  - MULT: {HI,LO} = signed(A) * signed(B), full 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Edge cases:
  - Divide by zero (B==0, op 2/3): busy runs the full DIV_LAT, then HI and LO are left unchanged.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no trap.
- Back-to-back: a new start is accepted on the edge after busy falls, i.e. the first cycle busy==0.
- The next sequential instruction issue sees busy==1. Only the immediate-cycle start case needs the start term in the stall rule.

Test Plan:
- Reset: hold reset=0 with clk running, release → busy=0, HI=0, LO=0. Assert reset=0 during cycle 3 of a DIV → busy=0 and HI=LO=0 immediately, with no later update.
- MULT: start, op=0, A=0xFFFFFFFE (−2), B=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU: same operands, op=1 → HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
- DIV / DIVU:
  - DIV, A=−7 (0xFFFFFFF9), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU, same operands → LO=0x7FFFFFFC, HI=0x00000001.
- Divide-by-zero and overflow:
  - Preload HI=0x11, LO=0x22 via MTHI/MTLO; DIV with B=0 → busy 10 cycles, then HI=0x11, LO=0x22.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Ignored start and operand latching:
  - During a MULT, issue start with op=4, A=0xDEAD → ignored; HI becomes the product, not 0xDEAD.
  - Change A/B after start → result still uses the originally latched operands.
  - MTLO with A=5 while idle → LO=5 one edge later, busy stays 0.
